run_ctrl: RTL and testbench



---
 rtl/run_ctrl.sv | 108 ++++++++++
 tb/tb_run_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Front-panel control: synchronizes, debounces and edge-detects three pushbuttons,
// then drives the divider speed select and the CPU run/pause and single-step controls.
module run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       btn_speed,
  input  logic       btn_run,
  input  logic       btn_step,
  output logic       choose,
  output logic       cpu_run,
  output logic       step_pulse,
  output logic [2:0] btn_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] PAUSE = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  localparam int B_SPEED = 0;
  localparam int B_RUN   = 1;
  localparam int B_STEP  = 2;

  logic [2:0]       w_raw;
  logic [2:0]       r_meta_p0;
  logic [2:0]       r_sync_p1;
  logic [CNT_W-1:0] r_cnt_p2 [3];
  logic [2:0]       r_stb_p2;
  logic [2:0]       r_stb_d_p3;
  logic [2:0]       w_ev;
  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             r_choose;
  logic             r_step_pulse;

  assign w_raw = {btn_step, btn_run, btn_speed};

  // Stage 0/1: two-flop synchronizer per button
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_meta_p0 <= 3'b000;
      r_sync_p1 <= 3'b000;
    end else begin
      r_meta_p0 <= w_raw;
      r_sync_p1 <= r_meta_p0;
    end
  end

  // Stage 2: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        r_cnt_p2[i] <= '0;
        r_stb_p2[i] <= 1'b0;
      end else if (r_sync_p1[i] == r_stb_p2[i]) begin
        r_cnt_p2[i] <= '0;
      end else if (r_cnt_p2[i] == CNT_MAX) begin
        r_stb_p2[i] <= r_sync_p1[i];
        r_cnt_p2[i] <= '0;
      end else begin
        r_cnt_p2[i] <= r_cnt_p2[i] + CNT_ONE;
      end
    end
  end

  // Stage 3: previous stable level for rising-edge detection
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_stb_d_p3 <= 3'b000;
    end else begin
      r_stb_d_p3 <= r_stb_p2;
    end
  end

  assign w_ev = r_stb_p2 & ~r_stb_d_p3;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PAUSE:   if (w_ev[B_RUN]) w_state_nxt = RUN;
      RUN:     if (w_ev[B_RUN]) w_state_nxt = PAUSE;
      default: w_state_nxt = PAUSE;
    endcase
  end

  // Stage 4: control state and registered outputs; run wins over a coincident step
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state      <= PAUSE;
      r_choose     <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_choose     <= r_choose ^ w_ev[B_SPEED];
      r_step_pulse <= (r_state == PAUSE) && w_ev[B_STEP] && !w_ev[B_RUN];
    end
  end

  assign choose     = r_choose;
  assign cpu_run    = (r_state == RUN);
  assign step_pulse = r_step_pulse;
  assign btn_state  = r_stb_p2;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed front-panel scenarios plus random button traffic,
// checked every cycle against a sliding-window reference model.
module tb_run_ctrl;

  localparam int D  = 4;
  localparam int CW = 3;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       btn_speed = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic       choose;
  logic       cpu_run;
  logic       step_pulse;
  logic [2:0] btn_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a level is accepted once the last D synchronized samples all disagree with it
  logic [2:0]   m_meta = '0;
  logic [D-1:0] m_win [3] = '{default: '0};
  logic [2:0]   m_stb = '0;
  logic [2:0]   m_stbd = '0;
  logic         m_choose = 1'b0;
  logic         m_run = 1'b0;
  logic         m_pulse = 1'b0;

  run_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .btn_speed  (btn_speed),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
    .choose     (choose),
    .cpu_run    (cpu_run),
    .step_pulse (step_pulse),
    .btn_state  (btn_state)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input logic rs, input logic [2:0] b);
    logic [2:0] ev;
    logic [2:0] nstb;
    if (rs) begin
      m_meta = '0;
      for (int i = 0; i < 3; i++) m_win[i] = '0;
      m_stb = '0; m_stbd = '0;
      m_choose = 1'b0; m_run = 1'b0; m_pulse = 1'b0;
    end else begin
      ev = m_stb & ~m_stbd;
      for (int i = 0; i < 3; i++)
        nstb[i] = (m_win[i] == {D{~m_stb[i]}}) ? ~m_stb[i] : m_stb[i];
      m_choose = m_choose ^ ev[0];
      m_pulse  = !m_run && ev[2] && !ev[1];
      if (ev[1]) m_run = !m_run;
      m_stbd = m_stb;
      m_stb  = nstb;
      for (int i = 0; i < 3; i++) m_win[i] = {m_win[i][D-2:0], m_meta[i]};
      m_meta = b;
    end
  endtask

  task automatic tick(input logic rs, input logic [2:0] b);
    rst = rs; btn_step = b[2]; btn_run = b[1]; btn_speed = b[0];
    @(posedge clk_in);
    model_step(rs, b);
    cyc++;
    #1;
    chk("choose",     32'(choose),     32'(m_choose));
    chk("cpu_run",    32'(cpu_run),    32'(m_run));
    chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
    chk("btn_state",  32'(btn_state),  32'(m_stb));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'b000);
  endtask

  initial begin
    int npulse, ppos, seen, ntog, tpos, jr, jc;
    logic prev_run, prev_choose;
    logic [2:0] cur;
    int hold [3];

    // Reset with all buttons held high
    tick(1'b1, 3'b111);
    tick(1'b1, 3'b111);
    chk("reset_outputs", 32'({choose, cpu_run, step_pulse, btn_state}), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 3'b000);
      seen = seen | int'({choose, cpu_run, step_pulse, btn_state});
    end
    chk("post_reset_quiet", 32'(seen), 32'd0);

    // Short speed glitch is rejected
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(1'b0, 3'b001); seen = seen | int'(btn_state[0]); end
    for (int i = 0; i < 8; i++) begin tick(1'b0, 3'b000); seen = seen | int'(btn_state[0]) | int'(choose); end
    chk("glitch_reject", 32'(seen), 32'd0);

    // Six-cycle press is accepted with fixed latency
    for (int j = 0; j < 6; j++) begin
      tick(1'b0, 3'b001);
      if (j == 4) chk("speed_stb_early", 32'(btn_state[0]), 32'd0);
      if (j == 5) chk("speed_stb_rise",  32'(btn_state[0]), 32'd1);
    end
    tick(1'b0, 3'b000);
    chk("choose_fast", 32'(choose), 32'd1);
    idle(8);

    // Step while paused: one pulse at offset 6
    npulse = 0; ppos = -1;
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 3'b100);
      if (step_pulse) begin npulse++; if (ppos < 0) ppos = j; end
    end
    chk("step_pulse_count", 32'(npulse), 32'd1);
    chk("step_pulse_pos",   32'(ppos),   32'd6);
    chk("step_keeps_pause", 32'(cpu_run), 32'd0);
    idle(8);

    for (int j = 0; j < 8; j++) tick(1'b0, 3'b010);
    chk("run_enter", 32'(cpu_run), 32'd1);
    idle(8);

    npulse = 0;
    for (int j = 0; j < 10; j++) begin tick(1'b0, 3'b100); if (step_pulse) npulse++; end
    chk("step_ignored_in_run", 32'(npulse), 32'd0);
    idle(8);

    for (int j = 0; j < 8; j++) tick(1'b0, 3'b010);
    chk("run_leave", 32'(cpu_run), 32'd0);
    idle(8);

    // Run and step together: run wins
    npulse = 0;
    for (int j = 0; j < 8; j++) begin tick(1'b0, 3'b110); if (step_pulse) npulse++; end
    chk("simul_run", 32'(cpu_run), 32'd1);
    chk("simul_no_pulse", 32'(npulse), 32'd0);
    idle(8);

    // Run, step and speed together: run and speed toggle on the same edge
    jr = -1; jc = -1; npulse = 0;
    for (int j = 0; j < 8; j++) begin
      prev_run = cpu_run; prev_choose = choose;
      tick(1'b0, 3'b111);
      if (cpu_run != prev_run && jr < 0) jr = j;
      if (choose != prev_choose && jc < 0) jc = j;
      if (step_pulse) npulse++;
    end
    chk("triple_run_pos",    32'(jr), 32'd6);
    chk("triple_choose_pos", 32'(jc), 32'd6);
    chk("triple_state", 32'({cpu_run, choose, step_pulse}), 32'd0);
    chk("triple_no_pulse", 32'(npulse), 32'd0);
    idle(8);

    // Bouncing run button then settling high
    ntog = 0; tpos = -1;
    for (int j = 0; j < 10; j++) begin
      prev_run = cpu_run;
      tick(1'b0, (j % 2 == 0) ? 3'b010 : 3'b000);
      if (cpu_run != prev_run) ntog++;
    end
    for (int j = 0; j < 12; j++) begin
      prev_run = cpu_run;
      tick(1'b0, 3'b010);
      if (cpu_run != prev_run) begin ntog++; if (tpos < 0) tpos = j; end
    end
    chk("bounce_toggles", 32'(ntog), 32'd1);
    chk("bounce_pos",     32'(tpos), 32'd6);
    idle(8);

    for (int j = 0; j < 8; j++) tick(1'b0, 3'b001);
    idle(8);
    chk("pre_reset_state", 32'({choose, cpu_run}), 32'b11);

    // Reset mid-count: debounce restarts from scratch
    tick(1'b0, 3'b010);
    tick(1'b0, 3'b010);
    tick(1'b1, 3'b010);
    chk("mid_reset_outs", 32'({choose, cpu_run, btn_state}), 32'd0);
    for (int n = 1; n <= 8; n++) begin
      tick(1'b0, 3'b010);
      if (n == 5) chk("restart_stb_early", 32'(btn_state[1]), 32'd0);
      if (n == 6) chk("restart_stb_rise",  32'(btn_state[1]), 32'd1);
      if (n == 7) chk("restart_run",       32'(cpu_run),      32'd1);
    end
    idle(8);

    // Random traffic: mixed glitches and holds with occasional reset
    cur = 3'b000;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          cur[i] = ~cur[i];
          hold[i] = int'($urandom_range(1, 12));
        end
        hold[i]--;
      end
      tick(($urandom_range(0, 149) == 0), cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
